// File: rtl/split_stream32.sv
// Serial-to-parallel splitter: fans a stream on in0 out into 32 held slots,
// one slot per running cycle, after a programmable start delay.
module split_stream32 #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 7,
  parameter int LEN_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
  output logic              done,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [DATA_W-1:0] out8,
  output logic [DATA_W-1:0] out9,
  output logic [DATA_W-1:0] out10,
  output logic [DATA_W-1:0] out11,
  output logic [DATA_W-1:0] out12,
  output logic [DATA_W-1:0] out13,
  output logic [DATA_W-1:0] out14,
  output logic [DATA_W-1:0] out15,
  output logic [DATA_W-1:0] out16,
  output logic [DATA_W-1:0] out17,
  output logic [DATA_W-1:0] out18,
  output logic [DATA_W-1:0] out19,
  output logic [DATA_W-1:0] out20,
  output logic [DATA_W-1:0] out21,
  output logic [DATA_W-1:0] out22,
  output logic [DATA_W-1:0] out23,
  output logic [DATA_W-1:0] out24,
  output logic [DATA_W-1:0] out25,
  output logic [DATA_W-1:0] out26,
  output logic [DATA_W-1:0] out27,
  output logic [DATA_W-1:0] out28,
  output logic [DATA_W-1:0] out29,
  output logic [DATA_W-1:0] out30,
  output logic [DATA_W-1:0] out31
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DIST
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0]  slot [32];
  logic [LEN_W-1:0]   idx, idx_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [DELAY_W-1:0] cnt, cnt_n;
  logic               done_n;
  logic               wr;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    cnt_n   = cnt;
    done_n  = done;
    wr      = 1'b0;
    if (running) begin
      unique case (state)
        WAIT: begin
          cnt_n = cnt - DELAY_W'(1);
          if (cnt <= DELAY_W'(1)) state_n = DIST;
        end
        DIST: begin
          wr = 1'b1;
          if (idx == len_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n = idx + LEN_W'(1);
          end
        end
        default: ;
      endcase
      // A run overrides the sequencing above but not this edge's write
      if (run) begin
        len_n   = length;
        idx_n   = '0;
        done_n  = 1'b0;
        cnt_n   = delay0;
        state_n = (delay0 == '0) ? DIST : WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      len_q <= '0;
      cnt   <= '0;
      done  <= 1'b1;
      for (int i = 0; i < 32; i++) slot[i] <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      len_q <= len_n;
      cnt   <= cnt_n;
      done  <= done_n;
      if (wr) slot[idx] <= in0;
    end
  end

  assign out0  = slot[0];
  assign out1  = slot[1];
  assign out2  = slot[2];
  assign out3  = slot[3];
  assign out4  = slot[4];
  assign out5  = slot[5];
  assign out6  = slot[6];
  assign out7  = slot[7];
  assign out8  = slot[8];
  assign out9  = slot[9];
  assign out10 = slot[10];
  assign out11 = slot[11];
  assign out12 = slot[12];
  assign out13 = slot[13];
  assign out14 = slot[14];
  assign out15 = slot[15];
  assign out16 = slot[16];
  assign out17 = slot[17];
  assign out18 = slot[18];
  assign out19 = slot[19];
  assign out20 = slot[20];
  assign out21 = slot[21];
  assign out22 = slot[22];
  assign out23 = slot[23];
  assign out24 = slot[24];
  assign out25 = slot[25];
  assign out26 = slot[26];
  assign out27 = slot[27];
  assign out28 = slot[28];
  assign out29 = slot[29];
  assign out30 = slot[30];
  assign out31 = slot[31];

endmodule

// File: tb/tb_split_stream32.sv
// Directed bench for split_stream32: reset, full/partial passes,
// freeze, restart, ignored run and mid-pass async reset.
module tb_split_stream32;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        running;
  logic        done;
  logic [6:0]  delay0;
  logic [4:0]  length;
  logic [31:0] in0;
  logic [31:0] o [32];
  logic [31:0] exp_s [32];

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  split_stream32 dut (
    .clk(clk), .rst(rst), .run(run), .running(running),
    .done(done), .delay0(delay0), .length(length), .in0(in0),
    .out0(o[0]),   .out1(o[1]),   .out2(o[2]),   .out3(o[3]),
    .out4(o[4]),   .out5(o[5]),   .out6(o[6]),   .out7(o[7]),
    .out8(o[8]),   .out9(o[9]),   .out10(o[10]), .out11(o[11]),
    .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
    .out16(o[16]), .out17(o[17]), .out18(o[18]), .out19(o[19]),
    .out20(o[20]), .out21(o[21]), .out22(o[22]), .out23(o[23]),
    .out24(o[24]), .out25(o[25]), .out26(o[26]), .out27(o[27]),
    .out28(o[28]), .out29(o[29]), .out30(o[30]), .out31(o[31])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exv);
    ntot++;
    assert (obs === exv) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exv);
  endtask

  task automatic chk_all(input string tag);
    for (int j = 0; j < 32; j++)
      chk($sformatf("%s slot%0d", tag, j), o[j], exp_s[j]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input nonzero; outputs must clear before any edge
    rst = 1'b1; run = 1'b1; running = 1'b1;
    delay0 = 7'd9; length = 5'd17; in0 = 32'hFFFF_FFFF;
    for (int j = 0; j < 32; j++) exp_s[j] = '0;
    #3;
    chk("reset done", {31'b0, done}, 32'd1);
    chk_all("reset");
    tick;
    rst = 1'b0; run = 1'b0;

    // Full pass, delay 3, length 31
    delay0 = 7'd3; length = 5'd31; run = 1'b1; in0 = 32'h1234_0000;
    tick;
    run = 1'b0;
    chk("full done low", {31'b0, done}, 32'd0);
    for (int d = 0; d < 3; d++) begin
      in0 = 32'hBAD0_0000 + d;
      tick;
      chk($sformatf("full wait%0d slot0", d), o[0], 32'd0);
    end
    for (int j = 0; j < 32; j++) begin
      in0 = 32'hC000_0000 + j;
      tick;
      exp_s[j] = 32'hC000_0000 + j;
      chk($sformatf("full w%0d", j), o[j], exp_s[j]);
      if (j < 31) chk($sformatf("full next%0d", j), o[j+1], exp_s[j+1]);
      chk($sformatf("full done%0d", j), {31'b0, done}, (j == 31) ? 1 : 0);
    end
    tick;
    chk_all("full end");

    // Preload 0xA5 everywhere, then zero delay with length 7
    delay0 = 7'd0; length = 5'd31; run = 1'b1; in0 = 32'hA5;
    tick;
    run = 1'b0;
    repeat (32) tick;
    for (int j = 0; j < 32; j++) exp_s[j] = 32'hA5;
    chk_all("preload");
    delay0 = 7'd0; length = 5'd7; run = 1'b1; in0 = 32'h0;
    tick;
    run = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in0 = j + 1;
      tick;
      exp_s[j] = j + 1;
      chk($sformatf("part w%0d", j), o[j], exp_s[j]);
      chk($sformatf("part done%0d", j), {31'b0, done}, (j == 7) ? 1 : 0);
    end
    in0 = 32'h7777_7777;
    repeat (3) tick;
    chk_all("part end");

    // Freeze for 5 cycles before slot 12
    delay0 = 7'd3; length = 5'd31; run = 1'b1;
    tick;
    run = 1'b0;
    repeat (3) tick;
    for (int j = 0; j < 32; j++) begin
      if (j == 12) begin
        running = 1'b0;
        for (int f = 0; f < 5; f++) begin
          in0 = 32'hDEAD_0000 + f;
          tick;
          chk($sformatf("frz%0d slot12", f), o[12], exp_s[12]);
          chk($sformatf("frz%0d done", f), {31'b0, done}, 32'd0);
        end
        running = 1'b1;
      end
      in0 = 32'h4000_0000 + j;
      tick;
      exp_s[j] = 32'h4000_0000 + j;
      chk($sformatf("frz w%0d", j), o[j], exp_s[j]);
      if (j < 31) chk($sformatf("frz next%0d", j), o[j+1], exp_s[j+1]);
    end
    chk("frz done", {31'b0, done}, 32'd1);
    chk_all("frz end");

    // Restart while idx=10
    delay0 = 7'd2; length = 5'd31; run = 1'b1;
    tick;
    run = 1'b0;
    repeat (2) tick;
    for (int j = 0; j < 10; j++) begin
      in0 = 32'h5000_0000 + j;
      tick;
      exp_s[j] = 32'h5000_0000 + j;
    end
    chk_all("rs before");
    delay0 = 7'd1; run = 1'b1; in0 = exp_s[10];
    tick;
    run = 1'b0;
    chk("rs done0", {31'b0, done}, 32'd0);
    in0 = 32'hBAD1_0000;
    tick;
    chk("rs wait done", {31'b0, done}, 32'd0);
    chk_all("rs wait");
    for (int j = 0; j < 32; j++) begin
      in0 = 32'h6000_0000 + j;
      tick;
      exp_s[j] = 32'h6000_0000 + j;
      chk($sformatf("rs w%0d", j), o[j], exp_s[j]);
      if (j < 31) chk($sformatf("rs keep%0d", j + 1), o[j+1], exp_s[j+1]);
      chk($sformatf("rs done%0d", j), {31'b0, done}, (j == 31) ? 1 : 0);
    end

    // Ignored run while not running
    running = 1'b0; run = 1'b1; delay0 = 7'd0; length = 5'd31;
    in0 = 32'hEEEE_EEEE;
    tick;
    run = 1'b0; running = 1'b1;
    repeat (2) tick;
    chk("ign done", {31'b0, done}, 32'd1);
    chk_all("ign");

    // Async reset in the middle of a pass
    run = 1'b1; delay0 = 7'd0;
    tick;
    run = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in0 = 32'h9000_0000 + j;
      tick;
      exp_s[j] = 32'h9000_0000 + j;
    end
    chk("mid done", {31'b0, done}, 32'd0);
    chk_all("mid");
    #1 rst = 1'b1;
    #1;
    for (int j = 0; j < 32; j++) exp_s[j] = '0;
    chk("arst done", {31'b0, done}, 32'd1);
    chk_all("arst");
    tick;
    rst = 1'b0;
    in0 = 32'h1111_1111;
    repeat (3) tick;
    chk("post rst done", {31'b0, done}, 32'd1);
    chk_all("post rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
